// File: rtl/posit_mul_arbiter.sv
// posit_mul_arbiter: round-robin front end that time-shares one fixed-latency
// posit multiplier core between NUM_REQ requesters. One operation is in flight
// at a time; each product is returned with the index of the requester that
// issued it.
// Build option: define POSIT_SPECIAL_BYPASS_EN to answer NaR/zero operand pairs
// directly at accept, without starting the core.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrating; req_ready asserted for the round-robin winner
// ISSUE  | core_start pulse; wait counter loaded with MUL_LAT
// WAIT   | core busy; product captured when the counter reaches 1
// RESP   | response presented, held until resp_ready

module posit_mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ES      = 3,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     core_start,
    output logic [WIDTH-1:0]         core_a,
    output logic [WIDTH-1:0]         core_b,
    input  logic [WIDTH-1:0]         core_res,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    // ES only documents the posit format of the attached core; it must still fit in a word.
    if (ES >= WIDTH) begin : g_bad_es
        $error("ES must be smaller than WIDTH");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_tc;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_nxt;
    logic [ID_W-1:0]   grant;
    logic              grant_found;
    logic [ID_W-1:0]   tag;
    logic [WIDTH-1:0]  grant_a;
    logic [WIDTH-1:0]  grant_b;
    logic              special_hit;
    logic [WIDTH-1:0]  special_res;

    // Circular priority scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        logic [ID_W:0] idx_ext;
        grant       = '0;
        grant_found = 1'b0;
        idx_ext     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_ext >= (ID_W+1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[idx_ext[ID_W-1:0]]) begin
                grant       = idx_ext[ID_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    assign grant_a = req_a[grant*WIDTH +: WIDTH];
    assign grant_b = req_b[grant*WIDTH +: WIDTH];
    assign rr_nxt  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign wait_tc = (wait_cnt == CNT_W'(1));

`ifdef POSIT_SPECIAL_BYPASS_EN
    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    // NaR dominates zero; either one makes the core result trivially known.
    always_comb begin
        special_hit = 1'b0;
        special_res = '0;
        if (grant_a == NAR || grant_b == NAR) begin
            special_hit = 1'b1;
            special_res = NAR;
        end else if (grant_a == '0 || grant_b == '0) begin
            special_hit = 1'b1;
            special_res = '0;
        end
    end
`else
    assign special_hit = 1'b0;
    assign special_res = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = special_hit ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_tc) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore-style outputs; req_ready also masked by rst so nothing is accepted during reset.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found && !rst) begin
            req_ready[grant] = 1'b1;
        end
        core_start = (state == S_ISSUE);
        busy       = (state != S_IDLE);
    end

    // Operand capture, round-robin pointer, wait timer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            tag        <= '0;
            core_a     <= '0;
            core_b     <= '0;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        core_a <= grant_a;
                        core_b <= grant_b;
                        tag    <= grant;
                        rr_ptr <= rr_nxt;
                        if (special_hit) begin
                            resp_data  <= special_res;
                            resp_id    <= grant;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CNT_W'(MUL_LAT);
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    // Counter at 1 marks the cycle core_res is valid.
                    if (wait_tc) begin
                        resp_data  <= core_res;
                        resp_id    <= tag;
                        resp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed bench for posit_mul_arbiter: main instance with MUL_LAT=3 plus two
// latency-sweep instances (MUL_LAT=1 and 5). Each has a core model that drives
// core_res only in the exact cycle the product is due.
module tb_posit_mul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] req_a, req_b;

    // main instance
    logic [3:0]  m_req_valid, m_req_ready;
    logic        m_core_start, m_resp_valid, m_resp_ready, m_busy;
    logic [31:0] m_core_a, m_core_b, m_core_res, m_resp_data;
    logic [1:0]  m_resp_id;

    // sweep instances
    logic [3:0]  s1_req_valid, s1_req_ready, s5_req_valid, s5_req_ready;
    logic        s1_core_start, s1_resp_valid, s1_busy, s5_core_start, s5_resp_valid, s5_busy;
    logic [31:0] s1_core_a, s1_core_b, s1_core_res, s1_resp_data;
    logic [31:0] s5_core_a, s5_core_b, s5_core_res, s5_resp_data;
    logic [1:0]  s1_resp_id, s5_resp_id;
    logic        sw_resp_ready;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int n_start = 0;
    int starts[$];

`ifdef POSIT_SPECIAL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    posit_mul_arbiter #(.WIDTH(32), .ES(3), .NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) u_main (
        .clk(clk), .rst(rst), .req_valid(m_req_valid), .req_ready(m_req_ready),
        .req_a(req_a), .req_b(req_b), .core_start(m_core_start), .core_a(m_core_a),
        .core_b(m_core_b), .core_res(m_core_res), .resp_valid(m_resp_valid),
        .resp_ready(m_resp_ready), .resp_id(m_resp_id), .resp_data(m_resp_data), .busy(m_busy));

    posit_mul_arbiter #(.WIDTH(32), .ES(3), .NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(s1_req_valid), .req_ready(s1_req_ready),
        .req_a(req_a), .req_b(req_b), .core_start(s1_core_start), .core_a(s1_core_a),
        .core_b(s1_core_b), .core_res(s1_core_res), .resp_valid(s1_resp_valid),
        .resp_ready(sw_resp_ready), .resp_id(s1_resp_id), .resp_data(s1_resp_data), .busy(s1_busy));

    posit_mul_arbiter #(.WIDTH(32), .ES(3), .NUM_REQ(4), .ID_W(2), .MUL_LAT(5)) u_lat5 (
        .clk(clk), .rst(rst), .req_valid(s5_req_valid), .req_ready(s5_req_ready),
        .req_a(req_a), .req_b(req_b), .core_start(s5_core_start), .core_a(s5_core_a),
        .core_b(s5_core_b), .core_res(s5_core_res), .resp_valid(s5_resp_valid),
        .resp_ready(sw_resp_ready), .resp_id(s5_resp_id), .resp_data(s5_resp_data), .busy(s5_busy));

    // Stand-in for the posit product: exact for posit 1.0 operands, otherwise a
    // scramble that still exposes any operand or timing mix-up.
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000) return b;
        if (b == 32'h4000_0000) return a;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [31:0] opa(input int i);
        return 32'h1111_1111 * (i + 1);
    endfunction

    function automatic logic [31:0] opb(input int i);
        return 32'h0F0F_0000 + i;
    endfunction

    // Core models: product valid only in the cycle MUL_LAT after core_start.
    logic [32:0] p_m [0:7];
    logic [32:0] p_1 [0:7];
    logic [32:0] p_5 [0:7];
    always @(posedge clk) begin
        p_m[0] <= {m_core_start, core_fn(m_core_a, m_core_b)};
        p_1[0] <= {s1_core_start, core_fn(s1_core_a, s1_core_b)};
        p_5[0] <= {s5_core_start, core_fn(s5_core_a, s5_core_b)};
        for (int i = 1; i < 8; i++) begin
            p_m[i] <= p_m[i-1];
            p_1[i] <= p_1[i-1];
            p_5[i] <= p_5[i-1];
        end
    end
    assign m_core_res  = p_m[2][32] ? p_m[2][31:0] : 32'hDEAD_BEEF;
    assign s1_core_res = p_1[0][32] ? p_1[0][31:0] : 32'hDEAD_BEEF;
    assign s5_core_res = p_5[4][32] ? p_5[4][31:0] : 32'hDEAD_BEEF;

    // Cycle counter and core_start monitor for the main instance.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (m_core_start) begin
            n_start <= n_start + 1;
            starts.push_back(cyc_n);
        end
    end

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // One operation on the main instance with resp_ready=1: grant, accept, latency, response.
    task automatic run_op(input string tag, input logic [1:0] exp_id, input logic [31:0] exp_data,
                          input int exp_lat, input bit drop);
        int w;
        int lat;
        logic [3:0] one;
        one = 4'b0001;
        #1;
        w = 0;
        while (m_req_ready == 4'b0 && w < 20) begin
            cyc();
            w++;
        end
        chk({tag, "_grant"}, m_req_ready, one << exp_id);
        @(posedge clk);
        #1;
        if (drop) m_req_valid = 4'b0;
        lat = 0;
        while (!m_resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_id"}, m_resp_id, exp_id);
        chk({tag, "_data"}, m_resp_data, exp_data);
        cyc();
    endtask

    initial begin
        int ns0;
        int w;
        int lat;
        logic [31:0] bp_data;

        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        m_req_valid = 4'hF;
        m_resp_ready = 1'b1;
        s1_req_valid = 4'b0;
        s5_req_valid = 4'b0;
        sw_resp_ready = 1'b1;

        // Reset state
        cyc();
        cyc();
        chk("rst_req_ready", m_req_ready, 4'b0);
        chk("rst_outputs", {m_core_start, m_core_a, m_core_b, m_resp_valid, m_resp_id, m_resp_data, m_busy},
            '0);
        chk("rst_sweep_busy", {s1_busy, s5_busy, s1_resp_valid, s5_resp_valid}, 4'b0);
        rst = 1'b0;
        m_req_valid = 4'b0;
        cyc();

        // Single op, 1.0 * 1.0 from requester 2
        set_op(2, 32'h4000_0000, 32'h4000_0000);
        m_req_valid = 4'b0100;
        ns0 = n_start;
        run_op("single", 2'd2, 32'h4000_0000, 4, 1'b1);
        chk("single_starts", n_start - ns0, 1);
        chk("single_idle", {m_resp_valid, m_busy}, 2'b00);
        chk("single_hold", {m_resp_id, m_resp_data, m_core_a}, {2'd2, 32'h4000_0000, 32'h4000_0000});

        // Fairness from a clean pointer
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, opa(i), opb(i));
        starts.delete();
        m_req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("fair%0d", i), 2'(i % 4), core_fn(opa(i % 4), opb(i % 4)), 4, 1'b0);
        end
        m_req_valid = 4'b0;
        chk("fair_nstarts", starts.size(), 8);
        for (int i = 1; i < 8 && i < starts.size(); i++) begin
            chk($sformatf("fair_spacing%0d", i), starts[i] - starts[i-1], 6);
        end
        cyc();

        // Backpressure on requester 1, requester 0 pending behind it
        m_resp_ready = 1'b0;
        m_req_valid = 4'b0010;
        #1;
        chk("bp_grant", m_req_ready, 4'b0010);
        cyc();
        m_req_valid = 4'b0001;
        lat = 0;
        while (!m_resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk("bp_lat", lat, 4);
        bp_data = core_fn(opa(1), opb(1));
        ns0 = n_start;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i), {m_resp_valid, m_resp_id, m_resp_data, m_busy, m_req_ready},
                {1'b1, 2'd1, bp_data, 1'b1, 4'b0000});
            cyc();
        end
        chk("bp_no_start", n_start - ns0, 0);
        m_resp_ready = 1'b1;
        cyc();
        chk("bp_release", {m_resp_valid, m_busy, m_req_ready}, {1'b0, 1'b0, 4'b0001});

        // Requester 0 accepted here; reset lands in its second WAIT cycle
        cyc();
        m_req_valid = 4'b0;
        cyc();
        cyc();
        rst = 1'b1;
        m_req_valid = 4'b1001;
        set_op(3, 32'h3333_0000, 32'h0000_5555);
        set_op(0, 32'h2222_0000, 32'h0000_7777);
        cyc();
        chk("wrst_outputs", {m_core_start, m_core_a, m_core_b, m_resp_valid, m_resp_id, m_resp_data, m_busy,
            m_req_ready}, '0);
        rst = 1'b0;
        m_req_valid = 4'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("wrst_quiet%0d", i), {m_resp_valid, m_core_start, m_busy}, 3'b000);
        end
        m_req_valid = 4'b1001;
        run_op("wrst_next", 2'd0, core_fn(32'h2222_0000, 32'h0000_7777), 4, 1'b1);

        // Latency sweep: MUL_LAT=1 on requester 0, MUL_LAT=5 on requester 3
        set_op(0, 32'hABCD_0123, 32'h1357_9BDF);
        s1_req_valid = 4'b0001;
        #1;
        w = 0;
        while (s1_req_ready == 4'b0 && w < 20) begin
            cyc();
            w++;
        end
        chk("lat1_grant", s1_req_ready, 4'b0001);
        cyc();
        s1_req_valid = 4'b0;
        lat = 0;
        while (!s1_resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk("lat1_lat", lat, 2);
        chk("lat1_resp", {s1_resp_id, s1_resp_data}, {2'd0, core_fn(32'hABCD_0123, 32'h1357_9BDF)});
        cyc();

        set_op(3, 32'h0246_8ACE, 32'h7531_FDB9);
        s5_req_valid = 4'b1000;
        #1;
        w = 0;
        while (s5_req_ready == 4'b0 && w < 20) begin
            cyc();
            w++;
        end
        chk("lat5_grant", s5_req_ready, 4'b1000);
        cyc();
        s5_req_valid = 4'b0;
        lat = 0;
        while (!s5_resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk("lat5_lat", lat, 6);
        chk("lat5_resp", {s5_resp_id, s5_resp_data}, {2'd3, core_fn(32'h0246_8ACE, 32'h7531_FDB9)});
        cyc();

        // Special operands on requester 2
        set_op(2, 32'h8000_0000, 32'h0000_0000);
        m_req_valid = 4'b0100;
        ns0 = n_start;
        run_op("sp_nar_zero", 2'd2, 32'h8000_0000, BYP ? 0 : 4, 1'b1);
        chk("sp_nar_zero_starts", n_start - ns0, BYP ? 0 : 1);

        set_op(2, 32'h1234_5678, 32'h0000_0000);
        m_req_valid = 4'b0100;
        ns0 = n_start;
        run_op("sp_zero", 2'd2, BYP ? 32'h0000_0000 : 32'h1234_5678, BYP ? 0 : 4, 1'b1);
        chk("sp_zero_starts", n_start - ns0, BYP ? 0 : 1);

        set_op(2, 32'h0000_0000, 32'h8000_0000);
        m_req_valid = 4'b0100;
        ns0 = n_start;
        run_op("sp_zero_nar", 2'd2, BYP ? 32'h8000_0000 : 32'h0000_8000, BYP ? 0 : 4, 1'b1);
        chk("sp_zero_nar_starts", n_start - ns0, BYP ? 0 : 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/posit_mul_arbiter.md
Name: posit_mul_arbiter

Overview:
- Round-robin scheduler that shares one fixed-latency posit multiplier core (WIDTH-bit, ES exponent bits) between NUM_REQ requesters.
- Accepts one operand pair at a time over valid/ready, pulses the core, waits MUL_LAT cycles, captures the product, and returns it tagged with the requester index over a valid/ready response channel.
- Sits between the posit_multiplier datapath and client engines (e.g. dot-product / MAC sequencers).

Parameters:
- WIDTH, 32, posit word width
- ES, 3, posit exponent field width; passed through for documentation, no logic depends on it
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, 2, width of requester tag; must equal clog2(NUM_REQ)
- MUL_LAT, 3, core latency in cycles from core_start to valid core_res (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_a  in  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- core_start  out  1  one-cycle pulse launching the core
- core_a  out  WIDTH  operand A to core; stable from ISSUE through the last WAIT cycle
- core_b  out  WIDTH  operand B to core; same stability as core_a
- core_res  in  WIDTH  core product; valid exactly MUL_LAT cycles after the core_start cycle
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  ID_W  index of the requester that owns the response
- resp_data  out  WIDTH  product
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; rr_ptr = 0.
  - core_start, core_a, core_b, resp_valid, resp_id, resp_data and busy are all 0.
  - req_ready = 0 while rst is high.
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Grant g = the first i with req_valid[i]=1, scanning circularly from rr_ptr.
  - req_ready[g] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - req_ready = 0 in every state other than IDLE.
  - On the handshake edge: capture req_a/req_b slice g into core_a/core_b, capture g into the tag register, set rr_ptr = (g+1) mod NUM_REQ, go to ISSUE.
  - No req_valid set: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - core_start = 1 for exactly this one cycle.
  - Load the wait counter with MUL_LAT; go to WAIT.
- WAIT:
  - Lasts exactly MUL_LAT cycles; the counter decrements each cycle.
  - In the final WAIT cycle (counter = 1), core_res is registered into resp_data and the tag into resp_id.
  - resp_valid = 1 from the next cycle; go to RESP.
- RESP:
  - resp_valid, resp_id and resp_data are held stable until resp_ready = 1.
  - On the handshake edge: resp_valid ← 0, go to IDLE.
  - resp_data and resp_id keep their last values after the handshake.
- Timing:
  - Minimum per-op occupancy = MUL_LAT + 3 cycles (accept, ISSUE, WAIT×MUL_LAT, RESP).
  - Request-accept edge to resp_valid high = MUL_LAT + 1 cycles.
- Requester rules:
  - A requester must hold req_valid and its operands stable until its req_ready is seen.
  - Dropping req_valid before grant is legal; that requester is simply not selected.
- Simultaneous events:
  - All requesters valid → grants rotate 0,1,2,3,0,…
  - A requester that re-asserts immediately after its grant waits behind all other pending requesters.
- Response backpressure: resp_ready held low indefinitely stalls the block in RESP; no new request is accepted.
- Reset mid-operation (ISSUE/WAIT/RESP):
  - The in-flight op is dropped; no response is produced.
  - The late core_res is ignored.
  - The next op starts clean from IDLE with rr_ptr = 0.
- The core is never started while a previous op is outstanding.

Optional Feature:
- Macro: POSIT_SPECIAL_BYPASS_EN
- Defined:
  - At accept, if either operand = NaR ({1'b1,{WIDTH-1{0}}}), result = NaR.
  - Else, if either operand = 0, result = 0.
  - NaR takes priority over zero.
  - For such ops, ISSUE/WAIT are skipped and core_start is not pulsed.
  - resp_data/resp_id are loaded on the accept edge, resp_valid is high in the next cycle, and the state goes to RESP.
  - rr_ptr updates as normal.
- Undefined: every accepted op goes through the core, including NaR/zero operands.

Test Plan:
- Single op, core model = 3-cycle multiply: req_valid[2]=1, a=0x40000000, b=0x40000000 → req_ready[2] one cycle; core_start 1 cycle later; resp_valid 4 cycles after accept with resp_id=2, resp_data=0x40000000.
- Fairness: all four req_valid held high for 8 ops, resp_ready=1 → resp_id sequence 0,1,2,3,0,1,2,3; every req_ready one-hot; core_start spaced 6 cycles apart.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp_data/resp_id stable, busy=1, no req_ready, no core_start; then resp_ready=1 → resp_valid=0 and IDLE next cycle.
- Reset in WAIT: rst pulsed 1 cycle during the 2nd WAIT cycle → resp_valid stays 0, all outputs 0; next request from requester 3 with requester 0 also valid → requester 0 granted first (rr_ptr reset to 0).
- Latency sweep, MUL_LAT=1 and MUL_LAT=5: core model produces its output only at the exact cycle → resp_data matches; accept-to-resp_valid = MUL_LAT+1 cycles.
- POSIT_SPECIAL_BYPASS_EN defined:
  - a=0x80000000, b=0x00000000 → resp_data=0x80000000 one cycle after accept, core_start never pulsed.
  - Without the macro → same operands pass through the core with full latency.
